// File: rtl/seq_muldiv.sv
// rtl/seq_muldiv.sv - iterative shift-add multiplier / restoring divider with start/busy/done handshake
module seq_muldiv #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             error,
   output logic             busy,
   output logic             done
);

   localparam int            CW     = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST   = CW'(WIDTH - 1);
   localparam logic [1:0]    OP_MUL = 2'b00;
   localparam logic [1:0]    OP_DIV = 2'b01;
   localparam logic [1:0]    OP_MOD = 2'b10;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] nxt_hi;
   logic [WIDTH-1:0] nxt_lo;

   // MUL: acc_hi:acc_lo is the product register, multiplier shifts out of acc_lo.
   // DIV/MOD: acc_hi is the remainder, acc_lo shifts dividend out and quotient in.
   always_comb begin
      sum     = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? a_q : {WIDTH{1'b0}})};
      shifted = {acc_hi, acc_lo[WIDTH-1]};
      diff    = shifted - {1'b0, b_q};
      if (op_q == OP_MUL) begin
         nxt_hi = sum[WIDTH:1];
         nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
      end else if (!diff[WIDTH]) begin
         nxt_hi = diff[WIDTH-1:0];
         nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
         nxt_hi = shifted[WIDTH-1:0];
         nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= '0;
         op_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         result <= '0;
         error  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  op_q   <= op;
                  a_q    <= a;
                  b_q    <= b;
                  cnt    <= '0;
                  acc_hi <= '0;
                  if (op == OP_MUL) begin
                     acc_lo <= b;
                     state  <= RUN;
                     busy   <= 1'b1;
                  end else if (op != 2'b11 && b != '0) begin
                     acc_lo <= a;
                     state  <= RUN;
                     busy   <= 1'b1;
                  end else begin
                     // divide-by-zero and reserved op complete on the accepting edge
                     done  <= 1'b1;
                     error <= 1'b1;
                     if (op == OP_DIV)
                        result <= '1;
                     else if (op == OP_MOD)
                        result <= a;
                     else
                        result <= '0;
                  end
               end
            end
            RUN: begin
               acc_hi <= nxt_hi;
               acc_lo <= nxt_lo;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  cnt   <= '0;
                  case (op_q)
                     OP_MUL: begin
                        result <= nxt_lo;
                        error  <= |nxt_hi;
                     end
                     OP_DIV: begin
                        result <= nxt_lo;
                        error  <= 1'b0;
                     end
                     default: begin
                        result <= nxt_hi;
                        error  <= 1'b0;
                     end
                  endcase
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_muldiv.sv
// tb/tb_seq_muldiv.sv - randomized self-checking bench for seq_muldiv at WIDTH 16 and 8
module tb_seq_muldiv;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, start8;
   logic [1:0]  op, op8;
   logic [15:0] a, b, result;
   logic [7:0]  a8, b8, result8;
   logic        error, busy, done;
   logic        error8, busy8, done8;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   seq_muldiv #(.WIDTH(16)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .result(result), .error(error), .busy(busy), .done(done)
   );

   seq_muldiv #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
      .result(result8), .error(error8), .busy(busy8), .done(done8)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: plain arithmetic on wide integers; returns {error, result}.
   function automatic logic [64:0] ref_op(input int w, input logic [1:0] o,
                                          input logic [63:0] x, input logic [63:0] y);
      logic [63:0] mask, p;
      mask = (64'd1 << w) - 64'd1;
      case (o)
         2'd0: begin
            p = x * y;
            return {((p >> w) != 0), p & mask};
         end
         2'd1:    return (y == 0) ? {1'b1, mask} : {1'b0, x / y};
         2'd2:    return (y == 0) ? {1'b1, x}    : {1'b0, x % y};
         default: return {1'b1, 64'd0};
      endcase
   endfunction

   task automatic run16(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y, input bit noise);
      logic [64:0] e;
      logic [15:0] prev;
      int          lat;
      bit          held;
      e    = ref_op(16, o, 64'(x), 64'(y));
      prev = result;
      held = 1'b1;
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0;
      lat   = 0;
      while (!done && lat < 40) begin
         if (result !== prev || busy !== 1'b1 || error === 1'bx) held = 1'b0;
         if (noise) begin
            a = 16'($urandom); b = 16'($urandom); op = 2'($urandom); start = 1'($urandom);
         end
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
      check("lat16", 64'(lat), (o == 2'd0 || (o != 2'd3 && y != 0)) ? 64'd16 : 64'd0);
      check("result16", 64'(result), e[63:0]);
      check("error16", 64'(error), 64'(e[64]));
      check("busy_at_done16", 64'(busy), 64'd0);
      check("hold16", 64'(held), 64'd1);
   endtask

   task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
      logic [64:0] e;
      int          lat;
      e = ref_op(8, o, 64'(x), 64'(y));
      @(negedge clk);
      start8 = 1'b1; op8 = o; a8 = x; b8 = y;
      @(posedge clk); #1;
      start8 = 1'b0;
      lat    = 0;
      while (!done8 && lat < 40) begin
         a8 = 8'($urandom); b8 = 8'($urandom);
         @(posedge clk); #1;
         lat++;
      end
      check("lat8", 64'(lat), (o == 2'd0 || (o != 2'd3 && y != 0)) ? 64'd8 : 64'd0);
      check("result8", 64'(result8), e[63:0]);
      check("error8", 64'(error8), 64'(e[64]));
   endtask

   initial begin
      #3000000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

   initial begin
      int n_done;
      logic [1:0]  ro;
      logic [15:0] rb;
      reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
      start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
      #12;
      check("rst_result", 64'(result), 64'd0);
      check("rst_error", 64'(error), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      @(negedge clk);
      reset = 1'b1;

      run16(2'd0, 16'd300, 16'd200, 1'b0);
      run16(2'd0, 16'd300, 16'd300, 1'b0);
      run16(2'd0, 16'hFFFF, 16'd1, 1'b0);
      run16(2'd1, 16'd1000, 16'd7, 1'b0);
      run16(2'd2, 16'd1000, 16'd7, 1'b0);
      run16(2'd1, 16'd1234, 16'd0, 1'b0);
      run16(2'd2, 16'd1234, 16'd0, 1'b0);
      run16(2'd3, 16'd55, 16'd66, 1'b0);
      run16(2'd0, 16'd5, 16'd5, 1'b1);

      // no queued operation may surface after an ignored start
      n_done = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
      check("no_queued_done", 64'(n_done), 64'd0);
      check("result_kept", 64'(result), 64'd25);

      // abort a DIV mid-run with an asynchronous reset
      @(negedge clk);
      start = 1'b1; op = 2'd1; a = 16'd50000; b = 16'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (8) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      check("abort_result", 64'(result), 64'd0);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_error", 64'(error), 64'd0);
      n_done = 0;
      repeat (3) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (20) begin
         @(posedge clk); #1;
         if (done) n_done++;
      end
      check("abort_no_done", 64'(n_done), 64'd0);
      run16(2'd1, 16'd50000, 16'd3, 1'b0);

      repeat (40) begin
         ro = 2'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 7)) : 16'($urandom);
         run16(ro, 16'($urandom), rb, 1'($urandom));
      end

      run8(2'd0, 8'd15, 8'd17);
      run8(2'd0, 8'd200, 8'd3);
      repeat (15) begin
         ro = 2'($urandom);
         run8(ro, 8'($urandom), ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom));
      end

      @(posedge clk); #1;
      check("done_drops16", 64'(done), 64'd0);
      check("done_drops8", 64'(done8), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/seq_muldiv.md
# seq_muldiv

Parametrised, multi-cycle multiply / divide / modulus unit for the ALU datapath. It replaces the single-cycle behavioural 16-bit multiplier, divider and modulus blocks with one iterative engine. It uses shift-add multiplication and restoring division, and exchanges operands through a start/busy/done handshake. Results and error flags keep the existing ALU semantics (low-half product with overflow flag, quotient, remainder, divide-by-zero flag) at any WIDTH.

## Interface
- WIDTH, 16: operand and result width in bits; legal range 4..64.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  request; sampled only while busy=0.
- op  input  2  operation: 00 = MUL, 01 = DIV, 10 = MOD, 11 = reserved.
- a  input  WIDTH  unsigned operand A (multiplicand / dividend).
- b  input  WIDTH  unsigned operand B (multiplier / divisor).
- result  output  WIDTH  registered result; held until the next completion.
- error  output  1  registered error flag; valid with result.
- busy  output  1  engine is iterating; start is ignored.
- done  output  1  one-cycle completion pulse.

## Operation
- States: IDLE, RUN. An iteration counter of width clog2(WIDTH)+1 counts 0..WIDTH-1.
- IDLE with start=1 at a clock edge:
  - Latch op, a and b.
  - op=MUL or op=DIV/MOD with b≠0: enter RUN and clear the counter.
  - op=DIV/MOD with b=0, or op=11: stay in IDLE and complete on this edge (fast path).
- MUL: 2·WIDTH-bit shift-add, one multiplier bit per cycle.
  - result = product[WIDTH-1:0].
  - error = OR of product[2·WIDTH-1:WIDTH].
- DIV/MOD: restoring division, one quotient bit per cycle, with a WIDTH+1-bit partial remainder.
  - DIV: result = quotient, error = 0.
  - MOD: result = remainder, error = 0.
- Fast path:
  - DIV by zero: result = all ones, error = 1.
  - MOD by zero: result = a, error = 1.
  - op=11: result = 0, error = 1.
- RUN lasts exactly WIDTH cycles. On the WIDTH-th edge: write result/error, pulse done, return to IDLE.
- Changes to a, b or op while busy have no effect; only the latched copies are used.
- start while busy=1 is ignored: not queued, no effect.
- result and error change only on a completion edge. Otherwise they hold their value.

## Timing
- Reset (reset=0, asynchronous): state = IDLE, result = 0, error = 0, busy = 0, done = 0, counter = 0, internal operand registers = 0.
- Release of reset is synchronous to clk. The first start is accepted on the first rising edge after reset=1.
- Normal latency, start accepted at edge E0:
  - busy = 1 from E0 to E_WIDTH.
  - At E_WIDTH: done = 1 for one cycle, result/error valid, busy = 0.
  - For WIDTH=16, done rises 16 cycles after the accepting edge.
- Fast-path latency: done = 1 and result/error valid after E0; busy stays 0.
- done is high for exactly one cycle per accepted start. It never asserts without a preceding accepted start.
- Back-to-back: start=1 in the done cycle (busy=0) is accepted on that edge.
- Reset mid-RUN: the operation is aborted immediately.
  - No done pulse; result is forced to 0.
  - The next start after release executes normally.

## Test plan
- MUL 300×200, WIDTH=16: start one cycle.
  - Response: busy high 16 cycles, then done one cycle, result = 60000 (0xEA60), error = 0.
- MUL 300×300, then MUL 0xFFFF×1 back-to-back (second start in the done cycle).
  - First: result = 0x5F90, error = 1.
  - Second: result = 0xFFFF, error = 0, done exactly 16 cycles after the first done.
- DIV 1000/7, then MOD 1000%7.
  - DIV: result = 142, error = 0.
  - MOD: result = 6, error = 0.
  - Each has 16-cycle latency.
- DIV 1234/0, MOD 1234/0, op=11.
  - DIV: done the edge after start, busy never high, result = 0xFFFF, error = 1.
  - MOD: result = 1234, error = 1.
  - op=11: result = 0, error = 1.
- MUL 5×5, then start=1 with op=DIV, a=9, b=3 at cycle 4 of RUN, and a/b toggled during RUN.
  - Exactly one done, result = 25.
  - No second done; the ignored start is not queued.
- Reset low at cycle 8 of a DIV 50000/3.
  - Outputs go to 0 immediately and no done pulse occurs.
  - After release, DIV 50000/3 yields result = 16666, error = 0.
  - Repeat with WIDTH=8: MUL 15×17 gives result = 255, error = 0, in 8 cycles.
